cska_pipe: RTL and testbench



---
 rtl/cska_pipe_if.sv | 28 ++
 rtl/cska_pipe.sv | 99 +++++++++
 tb/tb_cska_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cska_pipe_if.sv
// Streaming bundle for the pipelined carry-skip adder: operand beats in, result beats out.
// Handshake: a beat moves on a rising edge where valid && ready; the producer holds its data until that edge.
interface cska_pipe_if #(
  parameter int WIDTH = 16,
  parameter int NBLK  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic [NBLK-1:0]  skip;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout, ovf, skip
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout, ovf, skip
  );
endinterface

// File: rtl/cska_pipe.sv
// Pipelined carry-skip adder: register set 0 captures the operands, stage k adds block k
// and writes register set k+1, so a beat reaches the outputs NBLK edges after acceptance.
module cska_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input logic         clk_i,
  input logic         rst_ni,
  cska_pipe_if.slave  bus
);
  localparam int NBLK = WIDTH / BLOCK;

  if ((BLOCK < 1) || (WIDTH % BLOCK != 0)) begin : g_param_check
    $error("cska_pipe: WIDTH must be a positive multiple of BLOCK");
  end

  logic                en;
  logic [NBLK:0]       v_q;
  logic [NBLK:0]       c_q;
  logic [WIDTH-1:0]    a_q  [NBLK];
  logic [WIDTH-1:0]    b_q  [NBLK];
  logic [WIDTH-1:0]    s_q  [NBLK+1];
  logic [NBLK-1:0]     sk_q [NBLK+1];
  logic                ovf_q;

  // Stage k outputs, destined for register set k+1.
  logic [WIDTH-1:0]    s_d  [NBLK];
  logic [NBLK-1:0]     sk_d [NBLK];
  logic [NBLK-1:0]     c_d;
  logic                ovf_d;
  logic [BLOCK:0]      rc;
  logic [BLOCK-1:0]    p_bits;

  assign en = !v_q[NBLK] || bus.out_ready;

  always_comb begin
    c_d    = '0;
    ovf_d  = 1'b0;
    rc     = '0;
    p_bits = '0;
    for (int k = 0; k < NBLK; k++) begin
      s_d[k]  = s_q[k];
      sk_d[k] = sk_q[k];
      p_bits  = a_q[k][k*BLOCK +: BLOCK] ^ b_q[k][k*BLOCK +: BLOCK];
      rc[0]   = c_q[k];
      for (int i = 0; i < BLOCK; i++) begin
        s_d[k][k*BLOCK+i] = p_bits[i] ^ rc[i];
        rc[i+1] = (a_q[k][k*BLOCK+i] & b_q[k][k*BLOCK+i]) | (p_bits[i] & rc[i]);
      end
      // A fully propagating block forwards its incoming carry straight through.
      c_d[k]     = (&p_bits) ? c_q[k] : rc[BLOCK];
      sk_d[k][k] = &p_bits;
      if (k == NBLK - 1) begin
        ovf_d = rc[BLOCK-1] ^ c_d[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k <= NBLK; k++) begin
        s_q[k]  <= '0;
        sk_q[k] <= '0;
      end
      for (int k = 0; k < NBLK; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (en) begin
      v_q     <= {v_q[NBLK-1:0], bus.in_valid};
      a_q[0]  <= bus.a;
      b_q[0]  <= bus.b;
      c_q[0]  <= bus.cin;
      s_q[0]  <= '0;
      sk_q[0] <= '0;
      for (int k = 0; k < NBLK; k++) begin
        s_q[k+1]  <= s_d[k];
        sk_q[k+1] <= sk_d[k];
        c_q[k+1]  <= c_d[k];
      end
      // Operands skew forward so each stage sees its own block one edge later.
      for (int k = 0; k < NBLK - 1; k++) begin
        a_q[k+1] <= a_q[k];
        b_q[k+1] <= b_q[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = v_q[NBLK];
  assign bus.s         = s_q[NBLK];
  assign bus.cout      = c_q[NBLK];
  assign bus.ovf       = ovf_q;
  assign bus.skip      = sk_q[NBLK];
endmodule

// File: tb/tb_cska_pipe.sv
// Bench for cska_pipe: directed corner beats, backpressure, mid-flight reset and randomized
// traffic on a 16/4 instance, plus operand sweeps on 8-bit instances with BLOCK = 2, 8, 1.
module tb_cska_pipe;
  localparam int W  = 16;
  localparam int BK = 4;
  localparam int NB = W / BK;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (2) @(posedge clk);
    #1 s_rst_n = 1'b1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [W-1:0] last_s = '0;
  logic [2*W:0] exp_q[$];
  logic [W-1:0] ea, eb;
  logic         ecin;

  cska_pipe_if #(.WIDTH(W), .NBLK(NB)) m_if ();
  cska_pipe #(.WIDTH(W), .BLOCK(BK)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (m_if.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_sum(input logic [31:0] a, input logic [31:0] b, input logic cin);
    return 64'(a) + 64'(b) + 64'(cin);
  endfunction

  function automatic logic ref_ovf(input int w, input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [63:0] sum;
    sum = ref_sum(a, b, cin);
    return (a[w-1] == b[w-1]) && (sum[w-1] != a[w-1]);
  endfunction

  function automatic logic [31:0] ref_skip(input int w, input int blk, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, m;
    logic [31:0] r;
    r = '0;
    x = 64'(a ^ b);
    m = (64'd1 << blk) - 64'd1;
    for (int k = 0; k < w / blk; k++) r[k] = (((x >> (k * blk)) & m) == m);
    return r;
  endfunction

  // ---------------- scoreboard (main instance) ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", 64'(m_if.in_ready), 64'(!m_if.out_valid || m_if.out_ready));
      if (m_if.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(exp_q.size()), 64'd1);
        end else begin
          {ecin, ea, eb} = exp_q[0];
          check("sum", 64'({m_if.cout, m_if.s}), ref_sum(32'(ea), 32'(eb), ecin));
          check("ovf", 64'(m_if.ovf), 64'(ref_ovf(W, 32'(ea), 32'(eb), ecin)));
          check("skip", 64'(m_if.skip), 64'(ref_skip(W, BK, 32'(ea), 32'(eb))));
          if (m_if.out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
            last_s = m_if.s;
          end
        end
      end
      if (m_if.in_valid && m_if.in_ready) exp_q.push_back({m_if.cin, m_if.a, m_if.b});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    m_if.a = a;
    m_if.b = b;
    m_if.cin = cin;
    m_if.in_valid = 1'b1;
    while (!acc && tries < 100) begin
      @(negedge clk);
      acc = m_if.in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
    m_if.in_valid = 1'b0;
  endtask

  task automatic random_op(output logic [W-1:0] a, output logic [W-1:0] b, output logic cin);
    a = W'($urandom);
    cin = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0: b = W'($urandom);
      1: b = ~a;
      2: b = ~a ^ (W'(1) << $urandom_range(0, W - 1));
      default: b = W'($urandom_range(0, 3));
    endcase
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] xs, input logic xc, input logic xo, input logic [NB-1:0] xk);
    int lat;
    m_if.out_ready = 1'b1;
    m_if.a = a;
    m_if.b = b;
    m_if.cin = cin;
    m_if.in_valid = 1'b1;
    @(negedge clk);
    check("dir_in_ready", 64'(m_if.in_ready), 64'd1);
    @(posedge clk);
    #1;
    m_if.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!m_if.out_valid && lat < 20);
    check("dir_latency", 64'(lat), 64'(NB));
    check("dir_s", 64'(m_if.s), 64'(xs));
    check("dir_cout", 64'(m_if.cout), 64'(xc));
    check("dir_ovf", 64'(m_if.ovf), 64'(xo));
    check("dir_skip", 64'(m_if.skip), 64'(xk));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    m_if.out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- small-width instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_small
    localparam int SB = (g == 0) ? 2 : ((g == 1) ? 8 : 1);
    localparam int SN = 8 / SB;
    logic       done = 1'b0;
    logic [16:0] exp_q[$];
    logic [7:0] sa, sb;
    logic       scin;

    cska_pipe_if #(.WIDTH(8), .NBLK(SN)) s_if ();
    cska_pipe #(.WIDTH(8), .BLOCK(SB)) u_dut (
      .clk_i  (clk),
      .rst_ni (s_rst_n),
      .bus    (s_if.slave)
    );

    always @(negedge clk) begin
      if (s_rst_n) begin
        if (s_if.out_valid) begin
          if (exp_q.size() == 0) begin
            check($sformatf("s%0d_unexpected_out", SB), 64'(exp_q.size()), 64'd1);
          end else begin
            {scin, sa, sb} = exp_q[0];
            check($sformatf("s%0d_sum", SB), 64'({s_if.cout, s_if.s}), ref_sum(32'(sa), 32'(sb), scin));
            check($sformatf("s%0d_ovf", SB), 64'(s_if.ovf), 64'(ref_ovf(8, 32'(sa), 32'(sb), scin)));
            check($sformatf("s%0d_skip", SB), 64'(s_if.skip), 64'(ref_skip(8, SB, 32'(sa), 32'(sb))));
            if (s_if.out_ready) void'(exp_q.pop_front());
          end
        end
        if (s_if.in_valid && s_if.in_ready) exp_q.push_back({s_if.cin, s_if.a, s_if.b});
      end
    end

    initial begin
      logic [7:0] btab[8];
      logic acc;
      int tries, lat;
      s_if.in_valid = 1'b0;
      s_if.out_ready = 1'b1;
      s_if.a = '0;
      s_if.b = '0;
      s_if.cin = 1'b0;
      wait (s_rst_n);
      @(posedge clk);
      #1;
      s_if.a = 8'h3C;
      s_if.b = 8'hC3;
      s_if.cin = 1'b1;
      s_if.in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("s%0d_in_ready", SB), 64'(s_if.in_ready), 64'd1);
      @(posedge clk);
      #1;
      s_if.in_valid = 1'b0;
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!s_if.out_valid && lat < 20);
      check($sformatf("s%0d_latency", SB), 64'(lat), 64'(SN));
      // Every A against a spread of B values chosen to hit carry chains and full-propagate blocks.
      for (int a = 0; a < 256; a++) begin
        btab = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, ~8'(a), ~8'(a) ^ 8'h01, 8'(a)};
        for (int bi = 0; bi < 9; bi++) begin
          if ($urandom_range(0, 7) == 0) begin
            s_if.in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          s_if.a = 8'(a);
          s_if.b = (bi < 8) ? btab[bi] : 8'($urandom);
          s_if.cin = 1'($urandom_range(0, 1));
          s_if.in_valid = 1'b1;
          acc = 1'b0;
          tries = 0;
          while (!acc && tries < 50) begin
            s_if.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = s_if.in_ready;
            @(posedge clk);
            #1;
            tries++;
          end
          if (!acc) check($sformatf("s%0d_accept_timeout", SB), 64'(acc), 64'd1);
        end
      end
      s_if.in_valid = 1'b0;
      s_if.out_ready = 1'b1;
      tries = 0;
      while (exp_q.size() != 0 && tries < 100) begin
        @(posedge clk);
        #1;
        tries++;
      end
      check($sformatf("s%0d_drain", SB), 64'(exp_q.size()), 64'd0);
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] ra, rb;
    logic rc;
    int n0, t;
    bit rnd_done;

    m_if.in_valid = 1'b1;
    m_if.out_ready = 1'b1;
    m_if.a = W'($urandom);
    m_if.b = W'($urandom);
    m_if.cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(m_if.out_valid), 64'd0);
    check("rst_s", 64'(m_if.s), 64'd0);
    check("rst_cout", 64'(m_if.cout), 64'd0);
    check("rst_ovf", 64'(m_if.ovf), 64'd0);
    check("rst_skip", 64'(m_if.skip), 64'd0);
    rst_n = 1'b1;
    m_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(m_if.in_ready), 64'd1);

    directed(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110);
    directed(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b0110);
    directed(16'h0005, 16'h0003, 1'b1, 16'h0009, 1'b0, 1'b0, 4'b0000);

    // Eight back-to-back beats with the sink stalled for cycles 5..9.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          random_op(ra, rb, rc);
          drive_beat(ra, rb, rc);
        end
      end
      begin
        for (int c = 0; c < 20; c++) begin
          m_if.out_ready = !(c >= 5 && c <= 9);
          @(posedge clk);
          #1;
        end
      end
    join
    drain("bp_drain");
    check("bp_count", 64'(n_out - n0), 64'd8);

    n0 = n_out;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          random_op(ra, rb, rc);
          drive_beat(ra, rb, rc);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          m_if.out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    drain("rnd_drain");
    check("rnd_count", 64'(n_out - n0), 64'd400);

    // Three beats in flight with the head stalled, then a half-cycle reset pulse.
    m_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_beat(16'h1111 * W'(i + 1), 16'h0101, 1'b0);
    t = 0;
    while (!m_if.out_valid && t < 10) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("pre_rst_valid", 64'(m_if.out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_drop_valid", 64'(m_if.out_valid), 64'd0);
    exp_q.delete();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n0 = n_out;
    m_if.out_ready = 1'b1;
    drive_beat(16'h1234, 16'h4321, 1'b0);
    repeat (2 * NB + 2) @(posedge clk);
    #1;
    check("post_rst_count", 64'(n_out - n0), 64'd1);
    check("post_rst_s", 64'(last_s), 64'h5555);

    t = 0;
    while (!(g_small[0].done && g_small[1].done && g_small[2].done) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    check("small_done", 64'({g_small[0].done, g_small[1].done, g_small[2].done}), 64'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
